// File: rtl/serial_tx_param.sv
// Serial frame transmitter: start sequence then MSB-first payload, done pulse, optional idle gap.
// Define TRANS_PARITY_EN to append an even-parity bit after the payload.
module serial_tx_param #(
  parameter int                 DATA_W    = 55,
  parameter int                 SEQ_W     = 6,
  parameter logic [SEQ_W-1:0]   START_SEQ = 6'b011111,
  parameter int                 GAP       = 0,
  parameter int                 CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              s_data
);

`ifdef TRANS_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SEQ, ST_DATA, ST_PAR, ST_DONE, ST_GAP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_SEQ, ST_DATA, ST_DONE, ST_GAP} state_t;
`endif

  localparam logic [CNT_W-1:0] SEQ_CNT  = CNT_W'(SEQ_W);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEQ_W-1:0]    seq_sr_q, seq_sr_d;
  logic [DATA_W-1:0]   data_sr_q, data_sr_d;
  logic                sdat_d;
`ifdef TRANS_PARITY_EN
  logic                par_q, par_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_sr_d  = seq_sr_q;
    data_sr_d = data_sr_q;
    sdat_d    = 1'b0;
`ifdef TRANS_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // The first sequence bit goes out on the accept edge itself.
        if (start && ready) begin
          state_d   = ST_SEQ;
          cnt_d     = SEQ_CNT;
          seq_sr_d  = START_SEQ << 1;
          data_sr_d = tx_data;
          sdat_d    = START_SEQ[SEQ_W-1];
`ifdef TRANS_PARITY_EN
          par_d     = ^tx_data;
`endif
        end
      end
      ST_SEQ: begin
        if (cnt_q == CNT_ONE) begin
          state_d   = ST_DATA;
          cnt_d     = DATA_CNT;
          sdat_d    = data_sr_q[DATA_W-1];
          data_sr_d = data_sr_q << 1;
        end else begin
          cnt_d    = cnt_q - CNT_ONE;
          sdat_d   = seq_sr_q[SEQ_W-1];
          seq_sr_d = seq_sr_q << 1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d = '0;
`ifdef TRANS_PARITY_EN
          state_d = ST_PAR;
          sdat_d  = par_q;
`else
          state_d = ST_DONE;
`endif
        end else begin
          cnt_d     = cnt_q - CNT_ONE;
          sdat_d    = data_sr_q[DATA_W-1];
          data_sr_d = data_sr_q << 1;
        end
      end
`ifdef TRANS_PARITY_EN
      ST_PAR: state_d = ST_DONE;
`endif
      ST_DONE: begin
        if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_CNT;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and outputs: registered from next state so they align with s_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready   <= 1'b0;
      done    <= 1'b0;
      s_data  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= (state_d == ST_IDLE);
      done    <= (state_d == ST_DONE);
      s_data  <= sdat_d;
    end
  end

  // Shift registers are reloaded on every accept, so they carry no reset.
  always_ff @(posedge clk) begin
    seq_sr_q  <= seq_sr_d;
    data_sr_q <= data_sr_d;
`ifdef TRANS_PARITY_EN
    par_q     <= par_d;
`endif
  end

endmodule

// File: tb/tb_serial_tx_param.sv
// Directed bench for serial_tx_param: 8-bit/GAP=0, default 55-bit, and 8-bit/GAP=3 instances.
module tb_serial_tx_param;

`ifdef TRANS_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F8 = 14 + PB;
  localparam int FD = 61 + PB;
  localparam int PG = F8 + 2 + 3;

  logic        clk;
  logic        rst;
  logic [2:0]  start_v, ready_v, done_v, sdat_v;
  logic [7:0]  tx8, txg;
  logic [54:0] txd;

  int checks = 0;
  int errors = 0;

  serial_tx_param #(.DATA_W(8), .GAP(0)) u8 (
    .clk(clk), .rst(rst), .tx_data(tx8), .start(start_v[0]),
    .ready(ready_v[0]), .done(done_v[0]), .s_data(sdat_v[0]));

  serial_tx_param ud (
    .clk(clk), .rst(rst), .tx_data(txd), .start(start_v[1]),
    .ready(ready_v[1]), .done(done_v[1]), .s_data(sdat_v[1]));

  serial_tx_param #(.DATA_W(8), .GAP(3)) ug (
    .clk(clk), .rst(rst), .tx_data(txg), .start(start_v[2]),
    .ready(ready_v[2]), .done(done_v[2]), .s_data(sdat_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_frame(input logic [63:0] p, input int dw);
    logic [63:0] f;
    f = (64'h1F << dw) | p;
`ifdef TRANS_PARITY_EN
    f = {f[62:0], ^p};
`endif
    return f;
  endfunction

  task automatic send(input int w, input logic [63:0] p);
    case (w)
      0:       tx8 = p[7:0];
      1:       txd = p[54:0];
      default: txg = p[7:0];
    endcase
    start_v[w] = 1'b1;
    tick();
    start_v[w] = 1'b0;
  endtask

  task automatic collect(input int w, input int n, output logic [63:0] bits, output int early);
    bits  = '0;
    early = 0;
    for (int i = 0; i < n; i++) begin
      bits = {bits[62:0], sdat_v[w]};
      if (done_v[w]) early++;
      tick();
    end
  endtask

  task automatic frame_test(input int w, input logic [63:0] p, input int dw, input int f,
                            input string tag);
    logic [63:0] bits;
    int          early;
    send(w, p);
    collect(w, f, bits, early);
    check({tag, "_bits"}, bits, exp_frame(p, dw));
    check({tag, "_early_done"}, 64'(early), 64'd0);
    check({tag, "_done"}, 64'({done_v[w], sdat_v[w], ready_v[w]}), 64'b100);
    tick();
    check({tag, "_ready"}, 64'({ready_v[w], done_v[w]}), 64'b10);
  endtask

  initial begin
    logic [63:0] bits;
    int          early, nd, nr, bad;
    int          dpos [3];
    int          rpos [2];

    rst     = 1'b1;
    start_v = '0;
    tx8     = '0;
    txg     = '0;
    txd     = '0;

    // Reset hold and release
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold", 64'({ready_v, done_v, sdat_v}), 64'd0);
    end
    rst = 1'b0;
    tick();
    check("rst_release", 64'({ready_v, done_v, sdat_v}), {55'd0, 9'b111_000_000});

    // Basic 8-bit frames; A5 gives 0,1,1,1,1,1,1,0,1,0,0,1,0,1
    frame_test(0, 64'hA5, 8, F8, "basic_a5");
    frame_test(0, 64'h07, 8, F8, "basic_07");
`ifdef TRANS_PARITY_EN
    check("parity_07", exp_frame(64'h07, 8) & 64'h1, 64'h1);
`endif

    // Capture at accept, later tx_data change and ignored start
    txd = 55'h1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    bits  = '0;
    early = 0;
    for (int c = 0; c < FD; c++) begin
      bits = {bits[62:0], sdat_v[1]};
      if (done_v[1]) early++;
      if (c == 2) txd = '1;
      start_v[1] = (c == 19);
      tick();
    end
    check("cap_bits", bits, exp_frame(64'h1, 55));
    check("cap_early_done", 64'(early), 64'd0);
    check("cap_done", 64'(done_v[1]), 64'd1);
    tick();
    check("cap_ready", 64'({ready_v[1], done_v[1]}), 64'b10);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_v[1] || sdat_v[1] || !ready_v[1]) bad++;
    end
    check("cap_no_second", 64'(bad), 64'd0);

    // Back-to-back with GAP=3, start held high
    txg = 8'hA5;
    start_v[2] = 1'b1;
    tick();
    nd = 0;
    nr = 0;
    bits = '0;
    for (int t = 0; t < 3 * PG - 1; t++) begin
      if (done_v[2]) begin
        if (nd < 3) dpos[nd] = t;
        nd++;
      end
      if (ready_v[2]) begin
        if (nr < 2) rpos[nr] = t;
        nr++;
      end
      if (t >= PG && t < PG + F8) bits = {bits[62:0], sdat_v[2]};
      tick();
    end
    start_v[2] = 1'b0;
    check("b2b_ndone", 64'(nd), 64'd3);
    check("b2b_done0", 64'(dpos[0]), 64'(F8));
    check("b2b_done1", 64'(dpos[1]), 64'(F8 + PG));
    check("b2b_done2", 64'(dpos[2]), 64'(F8 + 2 * PG));
    check("b2b_nready", 64'(nr), 64'd2);
    check("b2b_ready0", 64'(rpos[0]), 64'(PG - 1));
    check("b2b_ready1", 64'(rpos[1]), 64'(2 * PG - 1));
    check("b2b_frame2", bits, exp_frame(64'hA5, 8));
    repeat (PG) tick();

    // Abort mid-frame, then a clean frame
    send(1, 64'h2A_AAAA_AAAA_AAAA);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("abort_rst", 64'({ready_v[1], done_v[1], sdat_v[1]}), 64'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done_v[1] || sdat_v[1]) bad++;
    end
    check("abort_quiet", 64'(bad), 64'd0);
    check("abort_ready", 64'(ready_v[1]), 64'd1);
    frame_test(1, 64'h5A_5A5A_5A5A_5A5A, 55, FD, "abort_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
